// File: rtl/eqy_miter_monitor.sv
// Verdict collector for an EQY miter in simulation: skips settle samples after start,
// then accumulates a sticky fail flag, first-failure point/cycle and a saturating mismatch count.
module eqy_miter_monitor #(
   parameter int NPOINTS      = 8,
   parameter int CYCW         = 16,
   parameter int CNTW         = 8,
   parameter int SETTLE       = 2,
   parameter int MAX_CYCLES   = 1000,
   parameter int STOP_ON_FAIL = 1,
   localparam int IDXW        = (NPOINTS > 1) ? $clog2(NPOINTS) : 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               stop,
   input  logic               cmp_valid,
   input  logic [NPOINTS-1:0] cmp_ok,
   input  logic [NPOINTS-1:0] cmp_def,
   output logic               busy,
   output logic               done,
   output logic               pass,
   output logic               fail,
   output logic [IDXW-1:0]    first_idx,
   output logic [CYCW-1:0]    first_cycle,
   output logic [CNTW-1:0]    mismatch_cnt,
   output logic [CYCW-1:0]    cycle_cnt,
   output logic [1:0]         o_dbg_state
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SETTLE = 2'd1,
      S_CHECK  = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   localparam logic [7:0]      SETTLE_LAST = (SETTLE > 0) ? 8'(SETTLE - 1) : 8'd0;
   localparam logic [CYCW-1:0] MAX_LAST    = CYCW'(MAX_CYCLES - 1);

   state_t            r_state;
   state_t            w_state_next;
   logic [7:0]        r_settle_cnt;
   logic              r_fail;
   logic [IDXW-1:0]   r_first_idx;
   logic [CYCW-1:0]   r_first_cycle;
   logic [CNTW-1:0]   r_mismatch_cnt;
   logic [CYCW-1:0]   r_cycle_cnt;

   logic [NPOINTS-1:0] w_bad;
   logic               w_sample_fail;
   logic               w_start_ok;
   logic               w_budget_hit;
   logic [IDXW-1:0]    w_low_idx;

   // A point only counts as mismatching where the gold side is defined.
   assign w_bad         = cmp_def & ~cmp_ok;
   assign w_sample_fail = cmp_valid & (|w_bad);
   assign w_start_ok    = start & ((r_state == S_IDLE) | (r_state == S_DONE));
   assign w_budget_hit  = cmp_valid & (r_cycle_cnt == MAX_LAST);

   // Priority scan from the top so the lowest set bit wins.
   always_comb begin
      w_low_idx = '0;
      for (int i = NPOINTS - 1; i >= 0; i--) begin
         if (w_bad[i]) w_low_idx = IDXW'(i);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE, S_DONE: begin
            if (start) w_state_next = (SETTLE > 0) ? S_SETTLE : S_CHECK;
         end
         S_SETTLE: begin
            if (stop)                                            w_state_next = S_DONE;
            else if (cmp_valid && (r_settle_cnt == SETTLE_LAST)) w_state_next = S_CHECK;
         end
         S_CHECK: begin
            if (stop || w_budget_hit || ((STOP_ON_FAIL != 0) && w_sample_fail))
               w_state_next = S_DONE;
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      case (r_state)
         S_SETTLE, S_CHECK: busy = 1'b1;
         S_DONE:            done = 1'b1;
         default:           ;
      endcase
      pass = done & ~r_fail;
   end

   // Verdict registers; a sample counted in the stop/budget cycle is still folded in.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_settle_cnt   <= '0;
         r_fail         <= 1'b0;
         r_first_idx    <= '0;
         r_first_cycle  <= '0;
         r_mismatch_cnt <= '0;
         r_cycle_cnt    <= '0;
      end else if (w_start_ok) begin
         r_settle_cnt   <= '0;
         r_fail         <= 1'b0;
         r_first_idx    <= '0;
         r_first_cycle  <= '0;
         r_mismatch_cnt <= '0;
         r_cycle_cnt    <= '0;
      end else begin
         case (r_state)
            S_SETTLE: begin
               if (cmp_valid) r_settle_cnt <= r_settle_cnt + 8'd1;
            end
            S_CHECK: begin
               if (cmp_valid) begin
                  r_cycle_cnt <= r_cycle_cnt + CYCW'(1);
                  if (w_sample_fail) begin
                     if (r_mismatch_cnt != '1) r_mismatch_cnt <= r_mismatch_cnt + CNTW'(1);
                     if (!r_fail) begin
                        r_fail        <= 1'b1;
                        r_first_idx   <= w_low_idx;
                        r_first_cycle <= r_cycle_cnt;
                     end
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign fail         = r_fail;
   assign first_idx    = r_first_idx;
   assign first_cycle  = r_first_cycle;
   assign mismatch_cnt = r_mismatch_cnt;
   assign cycle_cnt    = r_cycle_cnt;
   assign o_dbg_state  = r_state;

endmodule

// File: doc/eqy_miter_monitor.md
# eqy_miter_monitor

Sequential result collector placed directly downstream of an EQY-generated miter in simulation-based equivalence runs. Each cycle it samples the miter's per-match-point comparison results, discards a configurable number of settle samples after start, and accumulates a verdict: sticky fail flag, first-failure point index and cycle, and a saturating mismatch count. A bench or harness reads the verdict once `done` rises.

## Interface

Parameters:
- `NPOINTS`, 8, number of compared match points/outputs (≥1)
- `CYCW`, 16, width of cycle counter and `first_cycle`
- `CNTW`, 8, width of saturating mismatch counter
- `SETTLE`, 2, valid samples ignored after start (0..255)
- `MAX_CYCLES`, 1000, check-phase valid-sample budget before auto-finish (1..2^CYCW-1)
- `STOP_ON_FAIL`, 1, 1 = finish on first counted mismatch; 0 = run to budget/stop

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  clock, all state on rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `start`  in  1  begin a run; honoured only in IDLE or DONE
- `stop`  in  1  end the run early; honoured in SETTLE/CHECK
- `cmp_valid`  in  1  `cmp_ok`/`cmp_def` valid this cycle
- `cmp_ok`  in  NPOINTS  per-point equality (gold === gate)
- `cmp_def`  in  NPOINTS  per-point gold-defined mask; 0 = don't-care
- `busy`  out  1  high in SETTLE or CHECK
- `done`  out  1  high in DONE
- `pass`  out  1  high in DONE when `fail`=0
- `fail`  out  1  sticky: at least one counted mismatch this run
- `first_idx`  out  max(1,$clog2(NPOINTS))  lowest failing point of first failing sample
- `first_cycle`  out  CYCW  check-sample number (0-based) of first failing sample
- `mismatch_cnt`  out  CNTW  failing samples counted, saturating at all-ones
- `cycle_cnt`  out  CYCW  check-phase valid samples consumed

## Operation

- States: IDLE, SETTLE, CHECK, DONE.
- Sample mismatch vector: `bad = cmp_def & ~cmp_ok`; a sample fails when `cmp_valid` and `|bad`.
- IDLE/DONE + `start`: clear `fail`, `first_idx`, `first_cycle`, `mismatch_cnt`, `cycle_cnt`, settle counter; go SETTLE if SETTLE>0 else CHECK.
- SETTLE: each `cmp_valid` increments settle counter; failures ignored, `cycle_cnt` unchanged. After the SETTLE-th valid sample go CHECK.
- CHECK, on `cmp_valid`: `cycle_cnt` += 1; if failing: `mismatch_cnt` += 1 (saturate), and if `fail`=0 set `fail`, capture `first_idx` = lowest set bit of `bad`, `first_cycle` = pre-increment `cycle_cnt`.
- CHECK → DONE when: `stop`; or the valid sample bringing `cycle_cnt` to MAX_CYCLES; or STOP_ON_FAIL=1 and the sample fails.
- SETTLE + `stop` → DONE directly; `pass`=1 with `cycle_cnt`=0.
- DONE holds all results until next `start` or reset.
- `start` in SETTLE/CHECK ignored. `stop` in IDLE/DONE ignored.

## Timing

- Reset (async assert, sync release assumed from harness): state IDLE; `busy`, `done`, `pass`, `fail`, `first_idx`, `first_cycle`, `mismatch_cnt`, `cycle_cnt` all 0.
- Reset mid-run aborts immediately; no partial verdict retained.
- All outputs registered; a sample on edge N is reflected in outputs after edge N (visible cycle N+1).
- `start` at edge N: `busy`=1 from N+1; first sample consumed in the cycle after `start`, not the `start` cycle itself.
- `stop` and a valid sample in the same CHECK cycle: sample is counted, then DONE.
- Failing sample that also hits MAX_CYCLES: counted, DONE, `pass`=0.
- `start` in DONE: same edge clears results and leaves DONE; `done` drops at N+1.
- No `cmp_valid`: no counters advance; run lasts until `stop`.

## Test plan

- SETTLE=2, start, 2 valid samples with `cmp_ok`=0x00 `cmp_def`=0xFF, then MAX_CYCLES=5 clean samples → `done`=1, `pass`=1, `cycle_cnt`=5, `mismatch_cnt`=0.
- STOP_ON_FAIL=1, third check sample `cmp_ok`=0xF3 `cmp_def`=0xFF → `fail`=1, `first_idx`=2, `first_cycle`=2, `mismatch_cnt`=1, `done` next cycle.
- STOP_ON_FAIL=0, CNTW=2, 6 failing samples in 10 → `mismatch_cnt`=3 (saturated), `first_*` from first failure only.
- Mismatch on point with `cmp_def` bit 0 (`cmp_ok`=0xFE, `cmp_def`=0xFE) → no fail; `pass`=1 at budget.
- `stop` with a failing valid sample same cycle at check sample 0 → `fail`=1, `first_cycle`=0, `cycle_cnt`=1, DONE.
- `rst_n` low mid-CHECK after a failure → all outputs 0 immediately, state IDLE; `start` while busy has no effect on counts.
